// File: rtl/risc_pkg.sv
// Shared constants and types for the writeback path: data width, register
// count, register index type and the last-grant source encoding.
package risc_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RAW  = $clog2(NREG);

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  typedef logic [RAW-1:0]  reg_idx_t;
  typedef logic [XLEN-1:0] xdat_t;

endpackage

// File: rtl/wb_scheduler_if.sv
// Bus bundle between the writeback sources, the issue stage and the register file.
// WB_BYPASS_EN adds the forwarding outputs q_fwd0/1 and q_fdat0/1.
interface wb_scheduler_if;
  import risc_pkg::*;

  logic     alu_valid;
  reg_idx_t alu_rd;
  xdat_t    alu_dat;
  logic     alu_ready;

  logic     mem_valid;
  reg_idx_t mem_rd;
  xdat_t    mem_dat;
  logic     mem_ready;

  logic     iss_valid;
  reg_idx_t iss_rd;
  logic     iss_ready;

  reg_idx_t q_reg0;
  reg_idx_t q_reg1;
  logic     q_busy0;
  logic     q_busy1;
`ifdef WB_BYPASS_EN
  logic     q_fwd0;
  logic     q_fwd1;
  xdat_t    q_fdat0;
  xdat_t    q_fdat1;
`endif

  reg_idx_t w_reg;
  xdat_t    w_dat;
  logic     write;

  modport slave (
`ifdef WB_BYPASS_EN
    output q_fwd0, q_fwd1, q_fdat0, q_fdat1,
`endif
    input  alu_valid, alu_rd, alu_dat,
    output alu_ready,
    input  mem_valid, mem_rd, mem_dat,
    output mem_ready,
    input  iss_valid, iss_rd,
    output iss_ready,
    input  q_reg0, q_reg1,
    output q_busy0, q_busy1,
    output w_reg, w_dat, write
  );

  modport master (
`ifdef WB_BYPASS_EN
    input  q_fwd0, q_fwd1, q_fdat0, q_fdat1,
`endif
    output alu_valid, alu_rd, alu_dat,
    input  alu_ready,
    output mem_valid, mem_rd, mem_dat,
    input  mem_ready,
    output iss_valid, iss_rd,
    input  iss_ready,
    output q_reg0, q_reg1,
    input  q_busy0, q_busy1,
    input  w_reg, w_dat, write
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req[0]=ALU, req[1]=MEM. The last-grant
// flag only moves when adv reports a transfer, so a waiting source always wins next.
//
//   state  | meaning
//   WB_ALU | ALU won the last transfer, MEM wins the next tie
//   WB_MEM | MEM won the last transfer (reset), ALU wins the next tie
module rr_arb2
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  wb_src_e last_q;
  wb_src_e last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= WB_MEM;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == WB_MEM) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (adv && (gnt != 2'b00)) begin
      last_d = gnt[1] ? WB_MEM : WB_ALU;
    end
  end

endmodule

// File: rtl/wb_scheduler.sv
// Writeback scheduler: arbitrates ALU/load results onto the register file
// write port and tracks pending destinations. WB_BYPASS_EN enables forwarding.
module wb_scheduler #(
  parameter int XLEN = risc_pkg::XLEN,
  parameter int NREG = risc_pkg::NREG
) (
  input logic            clk,
  input logic            rst_n,
  wb_scheduler_if.slave  bus
);
  import risc_pkg::*;

  localparam int RAW = $clog2(NREG);

  logic [1:0]      gnt;
  logic            alu_fire;
  logic            mem_fire;
  logic            any_fire;
  logic [RAW-1:0]  win_rd;
  logic [XLEN-1:0] win_dat;
  logic            win_write;

  logic            write_q;
  logic [RAW-1:0]  w_reg_q;
  logic [XLEN-1:0] w_dat_q;

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;
  logic            iss_ok;
  logic            iss_fire;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.mem_valid, bus.alu_valid}),
    .adv   (any_fire),
    .gnt   (gnt)
  );

  assign bus.alu_ready = gnt[0];
  assign bus.mem_ready = gnt[1];
  assign alu_fire      = bus.alu_valid & gnt[0];
  assign mem_fire      = bus.mem_valid & gnt[1];
  assign any_fire      = alu_fire | mem_fire;

  assign win_rd    = mem_fire ? bus.mem_rd  : bus.alu_rd;
  assign win_dat   = mem_fire ? bus.mem_dat : bus.alu_dat;
  // x0 results are handshaken but never reach the register file.
  assign win_write = any_fire && (win_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      w_reg_q <= '0;
      w_dat_q <= '0;
    end else begin
      write_q <= win_write;
      if (win_write) begin
        w_reg_q <= win_rd;
        w_dat_q <= win_dat;
      end
    end
  end

  assign bus.write = write_q;
  assign bus.w_reg = w_reg_q;
  assign bus.w_dat = w_dat_q;

`ifdef WB_BYPASS_EN
  logic hit0;
  logic hit1;

  // A register being written this cycle may be reallocated in the same cycle.
  assign iss_ok = !sb_q[bus.iss_rd] || (write_q && (w_reg_q == bus.iss_rd));

  assign hit0        = write_q && (w_reg_q == bus.q_reg0) && (w_reg_q != '0);
  assign hit1        = write_q && (w_reg_q == bus.q_reg1) && (w_reg_q != '0);
  assign bus.q_fwd0  = hit0;
  assign bus.q_fwd1  = hit1;
  assign bus.q_fdat0 = w_dat_q;
  assign bus.q_fdat1 = w_dat_q;
  assign bus.q_busy0 = sb_q[bus.q_reg0] && !hit0;
  assign bus.q_busy1 = sb_q[bus.q_reg1] && !hit1;
`else
  assign iss_ok      = !sb_q[bus.iss_rd];
  assign bus.q_busy0 = sb_q[bus.q_reg0];
  assign bus.q_busy1 = sb_q[bus.q_reg1];
`endif

  assign bus.iss_ready = iss_ok;
  assign iss_fire      = bus.iss_valid && iss_ok && (bus.iss_rd != '0);

  // Set is applied after clear so a same-cycle reallocation stays pending.
  always_comb begin
    sb_d = sb_q;
    if (write_q) begin
      sb_d[w_reg_q] = 1'b0;
    end
    if (iss_fire) begin
      sb_d[bus.iss_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the scheduler.
module tb_wb_scheduler;
  import risc_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_scheduler_if bus ();

  wb_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: pending set, round-robin memory, last registered write.
  bit       pend [NREG];
  bit       m_last_mem;
  bit       m_write;
  reg_idx_t m_wreg;
  xdat_t    m_wdat;

  bit a_acc;
  bit m_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    m_last_mem = 1'b1;
    m_write    = 1'b0;
    m_wreg     = '0;
    m_wdat     = '0;
  endtask

  task automatic drive_idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_dat = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_dat = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.q_reg0    = '0;   bus.q_reg1 = '0;
  endtask

`ifdef WB_BYPASS_EN
  function automatic bit fwd_hit(input reg_idx_t q);
    return m_write && (m_wreg == q) && (q != '0);
  endfunction
`endif

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then check the registered write port just after the edge.
  task automatic cycle();
    bit ag, mg, irdy, b0, b1, nw;
    @(negedge clk);
    ag   = bus.alu_valid && (!bus.mem_valid || m_last_mem);
    mg   = bus.mem_valid && !ag;
    irdy = !pend[bus.iss_rd];
    b0   = pend[bus.q_reg0];
    b1   = pend[bus.q_reg1];
`ifdef WB_BYPASS_EN
    if (m_write && (m_wreg == bus.iss_rd)) irdy = 1'b1;
    if (fwd_hit(bus.q_reg0)) b0 = 1'b0;
    if (fwd_hit(bus.q_reg1)) b1 = 1'b0;
    chk("q_fwd0", bus.q_fwd0, fwd_hit(bus.q_reg0));
    chk("q_fwd1", bus.q_fwd1, fwd_hit(bus.q_reg1));
    if (fwd_hit(bus.q_reg0)) chk("q_fdat0", bus.q_fdat0, m_wdat);
    if (fwd_hit(bus.q_reg1)) chk("q_fdat1", bus.q_fdat1, m_wdat);
`endif
    chk("alu_ready", bus.alu_ready, ag);
    chk("mem_ready", bus.mem_ready, mg);
    chk("iss_ready", bus.iss_ready, irdy);
    chk("q_busy0", bus.q_busy0, b0);
    chk("q_busy1", bus.q_busy1, b1);
    a_acc = ag;
    m_acc = mg;

    if (m_write) pend[m_wreg] = 1'b0;
    if (bus.iss_valid && irdy && (bus.iss_rd != '0)) pend[bus.iss_rd] = 1'b1;
    if (ag || mg) m_last_mem = mg;
    nw = 1'b0;
    if (ag && (bus.alu_rd != '0)) begin
      nw = 1'b1; m_wreg = bus.alu_rd; m_wdat = bus.alu_dat;
    end else if (mg && (bus.mem_rd != '0)) begin
      nw = 1'b1; m_wreg = bus.mem_rd; m_wdat = bus.mem_dat;
    end
    m_write = nw;

    @(posedge clk);
    #1;
    chk("write", bus.write, m_write);
    chk("w_reg", bus.w_reg, m_wreg);
    chk("w_dat", bus.w_dat, m_wdat);
  endtask

  initial begin
    int hits;
    drive_idle();
    model_reset();

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_write", bus.write, 1'b0);
    chk("rst_w_reg", bus.w_reg, 0);
    chk("rst_w_dat", bus.w_dat, 0);
    chk("rst_busy0", bus.q_busy0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Contention: ALU first after reset, then strict alternation
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_dat = 32'hA5A5_0005;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd6; bus.mem_dat = 32'hB6B6_0006;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("cont_alu_gnt", a_acc, (i % 2) == 0);
      chk("cont_w_reg", bus.w_reg, (i % 2 == 0) ? 5 : 6);
    end
    drive_idle();
    cycle();
    chk("cont_idle_write", bus.write, 1'b0);

    // Scoreboard set, write-back, busy clear
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    cycle();
    bus.iss_valid = 1'b0; bus.q_reg0 = 5'd7;
    #1 chk("sb_busy7", bus.q_busy0, 1'b1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_dat = 32'hDEAD_BEEF;
    cycle();
    bus.alu_valid = 1'b0;
    chk("sb_wdat7", bus.w_dat, 32'hDEAD_BEEF);
    cycle();
    cycle();
    chk("sb_clear7", bus.q_busy0, 1'b0);

    // WAW stall until the rd=9 write-back
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    cycle();
    cycle();
    chk("waw_stall", a_acc | m_acc, 1'b0);
    cycle();
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_dat = 32'h0000_0999;
    cycle();
    bus.mem_valid = 1'b0;
    cycle();
    cycle();
    bus.iss_valid = 1'b0; bus.q_reg0 = 5'd9;
    cycle();
    chk("waw_busy9", bus.q_busy0, 1'b1);

    // x0: allocation ignored, write dropped
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.q_reg1 = 5'd0;
    cycle();
    bus.iss_valid = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_dat = 32'h0000_1234;
    cycle();
    chk("x0_mem_acc", m_acc, 1'b1);
    chk("x0_no_write", bus.write, 1'b0);
    bus.mem_valid = 1'b0;
    cycle();

    // Backpressure: MEM held stable against a busy ALU, delivered once
    hits = 0;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd10; bus.mem_dat = 32'hCAFE_0010;
    for (int i = 0; i < 5; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = reg_idx_t'(11 + i); bus.alu_dat = $urandom;
      cycle();
      if (m_acc) bus.mem_valid = 1'b0;
      if (bus.write && (bus.w_dat == 32'hCAFE_0010)) hits++;
    end
    chk("bp_once", hits, 1);
    drive_idle();
    cycle();

    // Reset mid-traffic drops the registered write and the scoreboard
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    cycle();
    bus.iss_valid = 1'b0; bus.q_reg0 = 5'd3;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_dat = 32'h3333_3333;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_write", bus.write, 1'b0);
    chk("mid_rst_w_reg", bus.w_reg, 0);
    chk("mid_rst_busy0", bus.q_busy0, 1'b0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    bus.alu_rd = 5'd4; bus.mem_valid = 1'b1; bus.mem_rd = 5'd8;
    cycle();
    chk("post_rst_alu_first", a_acc, 1'b1);
    drive_idle();
    cycle();

    // Random traffic with valid/data hold under backpressure
    a_acc = 1'b0;
    m_acc = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!(bus.alu_valid && !a_acc)) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_rd    = reg_idx_t'($urandom_range(0, 11));
        bus.alu_dat   = $urandom;
      end
      if (!(bus.mem_valid && !m_acc)) begin
        bus.mem_valid = 1'($urandom_range(0, 1));
        bus.mem_rd    = reg_idx_t'($urandom_range(0, 11));
        bus.mem_dat   = $urandom;
      end
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd    = reg_idx_t'($urandom_range(0, 11));
      bus.q_reg0    = reg_idx_t'($urandom_range(0, 11));
      bus.q_reg1    = reg_idx_t'($urandom_range(0, 11));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
